// File: rtl/val2_shift_pipe_if.sv
// val2_shift_pipe_if: request/result handshake bundle for val2_shift_pipe.
interface val2_shift_pipe_if #(parameter int DATA_W = 32);
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] reg2Val;
    logic [7:0]        rsVal;
    logic              immediate;
    logic              memEnable;
    logic [11:0]       shiftOperand;
    logic              carryIn;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] aluIn2Val;
    logic              shiftCarry;
    modport master (
        output inValid, reg2Val, rsVal, immediate, memEnable, shiftOperand, carryIn, outReady,
        input  inReady, outValid, aluIn2Val, shiftCarry
    );
    modport slave (
        input  inValid, reg2Val, rsVal, immediate, memEnable, shiftOperand, carryIn, outReady,
        output inReady, outValid, aluIn2Val, shiftCarry
    );
endinterface

// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe: two-stage second-operand generator (decode, barrel shift) with valid/ready.
// Register-specified shifts are built only when VAL2_REG_SHIFT_EN is defined.
module val2_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int OFFS_W = 12
) (
    input logic              clk,
    input logic              rst_n,
    val2_shift_pipe_if.slave io
);
    localparam int LW = $clog2(DATA_W);
    localparam logic [8:0] W9 = 9'(DATA_W);
    typedef enum logic [1:0] {M_LSL, M_LSR, M_ASR, M_ROR} mode_e;
    logic [DATA_W-1:0] val_d, val_q, res_d, res_q, shf;
    logic [8:0]        amt_d, amt_q;
    mode_e             mode_d, mode_q, op_mode;
    logic              fill_d, fill_q, cin_q, keep_d, keep_q, rrx_d, rrx_q, rmsb_d, rmsb_q;
    logic              cry_d, cry_q, s1_v_d, s1_v_q, out_v_d, out_v_q, acc, adv, lsl;
    logic [11:0]       op;
    logic [4:0]        iamt;
    logic [LW-1:0]     sh, cidx;
    logic [LW:0][DATA_W-1:0] lvl;
    assign op      = io.shiftOperand;
    assign iamt    = op[11:7];
    assign op_mode = mode_e'(op[6:5]);
    assign io.inReady   = rst_n && (!s1_v_q || !out_v_q || io.outReady);
    assign acc          = io.inValid && io.inReady;
    assign adv          = s1_v_q && (!out_v_q || io.outReady);
    assign s1_v_d       = acc || (s1_v_q && !adv);
    assign out_v_d      = adv || (out_v_q && !io.outReady);
    assign io.outValid  = out_v_q;
    assign io.aluIn2Val = res_q;
    assign io.shiftCarry = cry_q;
`ifndef VAL2_REG_SHIFT_EN
    logic unused_rs;
    assign unused_rs = ^io.rsVal;
`endif
    // Decode: fold every special case into keep/rrx/rmsb flags and an effective amount.
    always_comb begin
        val_d  = io.reg2Val;
        mode_d = op_mode;
        amt_d  = {4'd0, iamt};
        keep_d = 1'b0;
        rrx_d  = 1'b0;
        rmsb_d = 1'b0;
        if (io.memEnable) begin
            val_d  = {{(DATA_W-OFFS_W){op[OFFS_W-1]}}, op[OFFS_W-1:0]};
            keep_d = 1'b1;
        end else if (io.immediate) begin
            val_d  = {{(DATA_W-8){1'b0}}, op[7:0]};
            mode_d = M_ROR;
            amt_d  = {4'd0, op[11:8], 1'b0} & (W9 - 9'd1);
            keep_d = op[11:8] == 4'd0;
            rmsb_d = op[11:8] != 4'd0 && amt_d == 9'd0;
        end else if (op[4]) begin
`ifdef VAL2_REG_SHIFT_EN
            amt_d  = op_mode == M_ROR ? {1'b0, io.rsVal} & (W9 - 9'd1) : {1'b0, io.rsVal};
            keep_d = io.rsVal == 8'd0;
            rmsb_d = op_mode == M_ROR && io.rsVal != 8'd0 && amt_d == 9'd0;
`else
            keep_d = 1'b1;
`endif
        end else if (iamt == 5'd0) begin
            keep_d = op_mode == M_LSL;
            rrx_d  = op_mode == M_ROR;
            amt_d  = W9;
        end else if (op_mode == M_ROR) begin
            amt_d  = {4'd0, iamt} & (W9 - 9'd1);
            rmsb_d = amt_d == 9'd0;
        end
        fill_d = mode_d == M_ASR && val_d[DATA_W-1];
    end
    // LSL reuses the right-shift tree by bit-reversing around it.
    assign lsl  = mode_q == M_LSL;
    assign sh   = amt_q[LW-1:0];
    assign cidx = lsl ? -sh : sh - {{(LW-1){1'b0}}, 1'b1};
    for (genvar b = 0; b < DATA_W; b++) begin : g_rev
        assign lvl[0][b] = lsl ? val_q[DATA_W-1-b] : val_q[b];
        assign shf[b]    = lsl ? lvl[LW][DATA_W-1-b] : lvl[LW][b];
    end
    for (genvar l = 0; l < LW; l++) begin : g_lvl
        assign lvl[l+1] = !amt_q[l] ? lvl[l] :
            {(mode_q == M_ROR ? lvl[l][(1<<l)-1:0] : {(1<<l){fill_q}}), lvl[l][DATA_W-1:(1<<l)]};
    end
    always_comb begin
        res_d = shf;
        cry_d = val_q[cidx];
        if (keep_q) begin
            res_d = val_q;
            cry_d = cin_q;
        end else if (rrx_q) begin
            res_d = {cin_q, val_q[DATA_W-1:1]};
            cry_d = val_q[0];
        end else if (rmsb_q) begin
            res_d = val_q;
            cry_d = val_q[DATA_W-1];
        end else if (amt_q >= W9) begin
            res_d = {DATA_W{fill_q}};
            cry_d = mode_q == M_ASR ? fill_q : amt_q == W9 && (lsl ? val_q[0] : val_q[DATA_W-1]);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            out_v_q <= 1'b0;
            val_q   <= '0;
            amt_q   <= '0;
            mode_q  <= M_LSL;
            fill_q  <= 1'b0;
            cin_q   <= 1'b0;
            keep_q  <= 1'b0;
            rrx_q   <= 1'b0;
            rmsb_q  <= 1'b0;
            res_q   <= '0;
            cry_q   <= 1'b0;
        end else begin
            s1_v_q  <= s1_v_d;
            out_v_q <= out_v_d;
            if (acc) begin
                val_q  <= val_d;
                amt_q  <= amt_d;
                mode_q <= mode_d;
                fill_q <= fill_d;
                cin_q  <= io.carryIn;
                keep_q <= keep_d;
                rrx_q  <= rrx_d;
                rmsb_q <= rmsb_d;
            end
            if (adv) begin
                res_q <= res_d;
                cry_q <= cry_d;
            end
        end
    end
endmodule

// File: tb/tb_val2_shift_pipe.sv
// tb_val2_shift_pipe: vector table, back-pressure/reset sequences and a random scoreboard
// against an arithmetic reference model of the second-operand rules.
`timescale 1ns/1ps
module tb_val2_shift_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    val2_shift_pipe_if #(.DATA_W(32)) ifc ();
    val2_shift_pipe #(.DATA_W(32), .OFFS_W(12)) dut (.clk(clk), .rst_n(rst_n), .io(ifc));
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        im;
        logic        me;
        logic [11:0] op;
        logic        c;
        logic [31:0] ev;
        logic        ec;
    } vec_t;
    vec_t        tbl[$];
    logic [32:0] q[$];
    logic        stall = 1'b0;
    logic [32:0] held;
    logic [31:0] bp_rm [4];
    logic [11:0] bp_op [4];
    logic [11:0] r_op;
    logic [7:0]  r_rs;
    logic        acc;
    int          sel;
    int          k;

    function automatic logic [32:0] shift_ref(input logic [1:0] m, input logic [31:0] v, input int n);
        logic [63:0] t;
        logic signed [63:0] s;
        int r;
        case (m)
            2'd0: begin t = {32'd0, v} << n; return {t[32], t[31:0]}; end
            2'd1: begin t = {v, 32'd0} >> n; return {t[31], t[63:32]}; end
            2'd2: begin s = $signed({v, 32'd0}) >>> n; return {s[31], s[63:32]}; end
            default: begin
                r = n % 32;
                if (r == 0) return {v[31], v};
                t = {v, v} >> r;
                return {t[31], t[31:0]};
            end
        endcase
    endfunction

    function automatic logic [32:0] ref_model(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                                              input logic me, input logic [11:0] op, input logic c);
        logic [63:0] t;
        int n;
        if (me) return {c, {{20{op[11]}}, op}};
        if (im) begin
            n = 2 * int'(op[11:8]);
            t = {24'd0, op[7:0], 24'd0, op[7:0]} >> n;
            return {n == 0 ? c : t[31], t[31:0]};
        end
        if (op[4]) begin
`ifdef VAL2_REG_SHIFT_EN
            if (rs == 8'd0) return {c, rm};
            return shift_ref(op[6:5], rm, int'(rs));
`else
            return {c, rm};
`endif
        end
        n = int'(op[11:7]);
        if (n != 0) return shift_ref(op[6:5], rm, n);
        case (op[6:5])
            2'd0: return {c, rm};
            2'd3: return {rm[0], c, rm[31:1]};
            default: return shift_ref(op[6:5], rm, 32);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] rm, input logic [7:0] rs, input logic im,
                         input logic me, input logic [11:0] op, input logic c, input logic ordy);
        ifc.inValid      = iv;
        ifc.reg2Val      = rm;
        ifc.rsVal        = rs;
        ifc.immediate    = im;
        ifc.memEnable    = me;
        ifc.shiftOperand = op;
        ifc.carryIn      = c;
        ifc.outReady     = ordy;
    endtask

    // One cycle of streaming: hold check, drive, then log transfers into/out of the scoreboard.
    task automatic step(input logic iv, input logic [31:0] rm, input logic [7:0] rs, input logic im,
                        input logic me, input logic [11:0] op, input logic c, input logic ordy,
                        output logic accepted);
        logic [32:0] e;
        @(negedge clk);
        if (stall) chk("hold", {31'd0, ifc.shiftCarry, ifc.aluIn2Val}, {31'd0, held});
        drive(iv, rm, rs, im, me, op, c, ordy);
        #1;
        accepted = iv && ifc.inReady;
        if (accepted) q.push_back(ref_model(rm, rs, im, me, op, c));
        if (ifc.outValid && ordy) begin
            if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("sb_val", {32'd0, ifc.aluIn2Val}, {32'd0, e[31:0]});
                chk("sb_carry", {63'd0, ifc.shiftCarry}, {63'd0, e[32]});
            end
        end
        stall = ifc.outValid && !ordy;
        held  = {ifc.shiftCarry, ifc.aluIn2Val};
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        @(negedge clk);
        drive(1'b1, v.rm, v.rs, v.im, v.me, v.op, v.c, 1'b1);
        #1 chk({nm, "_rdy"}, {63'd0, ifc.inReady}, 64'd1);
        @(posedge clk);
        #1 ifc.inValid = 1'b0;
        chk({nm, "_lat1"}, {63'd0, ifc.outValid}, 64'd0);
        @(posedge clk);
        #1 chk({nm, "_valid"}, {63'd0, ifc.outValid}, 64'd1);
        chk({nm, "_val"}, {32'd0, ifc.aluIn2Val}, {32'd0, v.ev});
        chk({nm, "_c"}, {63'd0, ifc.shiftCarry}, {63'd0, v.ec});
    endtask

    initial begin
        tbl.push_back('{32'h0, 8'd0, 1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF000000, 1'b1});
        tbl.push_back('{32'h00000003, 8'd0, 1'b0, 1'b0, 12'h060, 1'b1, 32'h80000001, 1'b1});
        tbl.push_back('{32'h80000000, 8'd0, 1'b0, 1'b0, 12'h020, 1'b0, 32'h00000000, 1'b1});
        tbl.push_back('{32'h0, 8'd0, 1'b0, 1'b1, 12'hFFC, 1'b1, 32'hFFFFFFFC, 1'b1});
        tbl.push_back('{32'h0, 8'd0, 1'b0, 1'b1, 12'hFFC, 1'b0, 32'hFFFFFFFC, 1'b0});
        tbl.push_back('{32'h12345678, 8'd0, 1'b0, 1'b0, 12'h000, 1'b1, 32'h12345678, 1'b1});
        tbl.push_back('{32'h80000000, 8'd0, 1'b0, 1'b0, 12'h040, 1'b0, 32'hFFFFFFFF, 1'b1});
        tbl.push_back('{32'hF0000001, 8'd0, 1'b0, 1'b0, 12'h200, 1'b0, 32'h00000010, 1'b1});
        tbl.push_back('{32'h0, 8'd0, 1'b1, 1'b0, 12'h0AB, 1'b1, 32'h000000AB, 1'b1});
        tbl.push_back('{32'h80000001, 8'd0, 1'b0, 1'b0, 12'h0C0, 1'b0, 32'hC0000000, 1'b1});
        tbl.push_back('{32'h00000003, 8'd0, 1'b0, 1'b0, 12'h0A0, 1'b0, 32'h00000001, 1'b1});
        tbl.push_back('{32'h12345678, 8'd0, 1'b0, 1'b0, 12'h460, 1'b1, 32'h78123456, 1'b0});
`ifdef VAL2_REG_SHIFT_EN
        tbl.push_back('{32'h00000001, 8'd32, 1'b0, 1'b0, 12'h010, 1'b0, 32'h00000000, 1'b1});
        tbl.push_back('{32'h00000001, 8'd33, 1'b0, 1'b0, 12'h010, 1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{32'h80000000, 8'd64, 1'b0, 1'b0, 12'h070, 1'b0, 32'h80000000, 1'b1});
        tbl.push_back('{32'h80000001, 8'd40, 1'b0, 1'b0, 12'h050, 1'b0, 32'hFFFFFFFF, 1'b1});
`else
        tbl.push_back('{32'h00000001, 8'd32, 1'b0, 1'b0, 12'h010, 1'b0, 32'h00000001, 1'b0});
        tbl.push_back('{32'h00000001, 8'd33, 1'b0, 1'b0, 12'h010, 1'b1, 32'h00000001, 1'b1});
        tbl.push_back('{32'h80000000, 8'd64, 1'b0, 1'b0, 12'h070, 1'b0, 32'h80000000, 1'b0});
`endif
        // Reset: outputs clear, inReady low while held, inValid ignored.
        drive(1'b1, 32'hDEADBEEF, 8'd0, 1'b0, 1'b0, 12'h200, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("rst_valid", {63'd0, ifc.outValid}, 64'd0);
        chk("rst_val", {32'd0, ifc.aluIn2Val}, 64'd0);
        chk("rst_carry", {63'd0, ifc.shiftCarry}, 64'd0);
        chk("rst_inready", {63'd0, ifc.inReady}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.inValid = 1'b0;
        #1 chk("rel_inready", {63'd0, ifc.inReady}, 64'd1);
        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));
        @(negedge clk);
        drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        // Back-pressure: four requests, outReady low for the first three cycles.
        for (int i = 0; i < 4; i++) begin
            bp_rm[i] = $urandom;
            bp_op[i] = {5'(i + 1), 2'(i), 1'b0, 4'h0};
        end
        k = 0;
        for (int cy = 0; cy < 12 && k < 4; cy++) begin
            step(1'b1, bp_rm[k], 8'd0, 1'b0, 1'b0, bp_op[k], 1'b1, cy >= 3, acc);
            if (acc) k++;
            if (cy == 2) chk("bp_accepts", 64'(k), 64'd2);
        end
        chk("bp_all_in", 64'(k), 64'd4);
        repeat (5) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, acc);
        chk("bp_drained", 64'(q.size()), 64'd0);
        // Reset mid-stall with both stages full.
        step(1'b1, 32'hAAAA5555, 8'd0, 1'b0, 1'b0, 12'h0E0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h5555AAAA, 8'd0, 1'b1, 1'b0, 12'h3F1, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        ifc.inValid = 1'b1;
        @(posedge clk);
        #1 chk("mrst_valid", {63'd0, ifc.outValid}, 64'd0);
        chk("mrst_val", {32'd0, ifc.aluIn2Val}, 64'd0);
        chk("mrst_carry", {63'd0, ifc.shiftCarry}, 64'd0);
        chk("mrst_inready", {63'd0, ifc.inReady}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.inValid = 1'b0;
        ifc.outReady = 1'b1;
        q.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("mrst_no_ghost", {63'd0, ifc.outValid}, 64'd0);
        apply_vec(tbl[0], "post_rst");
        @(negedge clk);
        drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        // Random stream against the reference model.
        for (int i = 0; i < 1500; i++) begin
            r_op = 12'($urandom);
            sel  = $urandom_range(0, 9);
            r_rs = sel < 3 ? 8'(32 * sel + $urandom_range(0, 1)) : 8'($urandom);
            step($urandom_range(0, 3) != 0, $urandom, r_rs, sel == 9, sel == 8, r_op, 1'($urandom),
                 $urandom_range(0, 3) != 0, acc);
        end
        repeat (4) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, acc);
        chk("rnd_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
